// File: rtl/mvm_load_sequencer.sv
// Load sequencer for one matrix-vector multiply on the 8x8 MAC datapath.
// It fetches the matrix A columns and the vector B over a read port that allows one
// outstanding read. It loads the A and B FIFOs, then enables the MACs until the FIFOs
// drain, adds a fixed pipeline tail, and pulses done.
module mvm_load_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int DIM        = 8,
   parameter int ADDR_WIDTH = 32,
   parameter int TAIL_CYC   = 9
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [ADDR_WIDTH-1:0]     base_addr,
   output logic                      busy,
   output logic                      done,
   output logic [15:0]               job_cycles,
   output logic [ADDR_WIDTH-1:0]     mem_address,
   output logic                      mem_read,
   input  logic                      mem_waitrequest,
   input  logic [DIM*DATA_WIDTH-1:0] mem_readdata,
   input  logic                      mem_readdatavalid,
   output logic                      a_wren,
   output logic [DIM*DATA_WIDTH-1:0] a_data,
   output logic                      b_wren,
   output logic [DATA_WIDTH-1:0]     b_data,
   input  logic                      fifo_full_all,
   input  logic                      fifo_empty_all,
   output logic                      mac_clr,
   output logic                      mac_en
);

   localparam int CW = $clog2(DIM) + 1;
   localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int TW = $clog2(TAIL_CYC) + 1;
   localparam int WW = DIM * DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE, CLEAR, RD_A, RD_B, PUSH_B, COMPUTE, DRAIN, DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] baseAddr_q, baseAddr_d;
   logic [CW-1:0]         col_q, col_d;
   logic                  rdIssued_q, rdIssued_d;
   logic                  aPending_q, aPending_d;
   logic [WW-1:0]         aBuf_q, aBuf_d;
   logic [WW-1:0]         bBuf_q, bBuf_d;
   logic [IW-1:0]         pushIdx_q, pushIdx_d;
   logic                  seenFull_q, seenFull_d;
   logic [TW-1:0]         tailCnt_q, tailCnt_d;
   logic [15:0]           jobCycles_q, jobCycles_d;

   assign busy       = (state_q != IDLE);
   assign job_cycles = jobCycles_q;

   // State and working registers; a reset abandons any job in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         baseAddr_q  <= '0;
         col_q       <= '0;
         rdIssued_q  <= 1'b0;
         aPending_q  <= 1'b0;
         aBuf_q      <= '0;
         bBuf_q      <= '0;
         pushIdx_q   <= '0;
         seenFull_q  <= 1'b0;
         tailCnt_q   <= '0;
         jobCycles_q <= '0;
      end else begin
         state_q     <= state_d;
         baseAddr_q  <= baseAddr_d;
         col_q       <= col_d;
         rdIssued_q  <= rdIssued_d;
         aPending_q  <= aPending_d;
         aBuf_q      <= aBuf_d;
         bBuf_q      <= bBuf_d;
         pushIdx_q   <= pushIdx_d;
         seenFull_q  <= seenFull_d;
         tailCnt_q   <= tailCnt_d;
         jobCycles_q <= jobCycles_d;
      end
   end

   // Next-state logic and outputs; reads hold address/request until accepted, FIFO strobes wait out a full flag.
   always_comb begin
      state_d     = state_q;
      baseAddr_d  = baseAddr_q;
      col_d       = col_q;
      rdIssued_d  = rdIssued_q;
      aPending_d  = aPending_q;
      aBuf_d      = aBuf_q;
      bBuf_d      = bBuf_q;
      pushIdx_d   = pushIdx_q;
      seenFull_d  = seenFull_q;
      tailCnt_d   = tailCnt_q;
      jobCycles_d = jobCycles_q;
      done        = 1'b0;
      mem_address = '0;
      mem_read    = 1'b0;
      a_wren      = 1'b0;
      a_data      = '0;
      b_wren      = 1'b0;
      b_data      = '0;
      mac_clr     = 1'b0;
      mac_en      = 1'b0;

      if (state_q == IDLE) begin
         if (start) jobCycles_d = '0;
      end else if (jobCycles_q != 16'hFFFF) begin
         jobCycles_d = jobCycles_q + 16'd1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = CLEAR;
               baseAddr_d = base_addr;
            end
         end
         CLEAR: begin
            mac_clr    = 1'b1;
            col_d      = '0;
            rdIssued_d = 1'b0;
            aPending_d = 1'b0;
            pushIdx_d  = '0;
            seenFull_d = 1'b0;
            tailCnt_d  = '0;
            state_d    = RD_A;
         end
         RD_A: begin
            mem_address = baseAddr_q + ADDR_WIDTH'(col_q);
            if (aPending_q) begin
               if (!fifo_full_all) begin
                  a_wren     = 1'b1;
                  a_data     = aBuf_q;
                  aPending_d = 1'b0;
                  col_d      = col_q + CW'(1);
                  if (col_q == CW'(DIM - 1)) state_d = RD_B;
               end
            end else if (!rdIssued_q) begin
               mem_read = 1'b1;
               if (!mem_waitrequest) rdIssued_d = 1'b1;
            end else if (mem_readdatavalid) begin
               aBuf_d     = mem_readdata;
               aPending_d = 1'b1;
               rdIssued_d = 1'b0;
            end
         end
         RD_B: begin
            mem_address = baseAddr_q + ADDR_WIDTH'(col_q);
            if (!rdIssued_q) begin
               mem_read = 1'b1;
               if (!mem_waitrequest) rdIssued_d = 1'b1;
            end else if (mem_readdatavalid) begin
               bBuf_d     = mem_readdata;
               rdIssued_d = 1'b0;
               pushIdx_d  = '0;
               state_d    = PUSH_B;
            end
         end
         PUSH_B: begin
            if (!fifo_full_all) begin
               b_wren    = 1'b1;
               b_data    = bBuf_q[int'(pushIdx_q) * DATA_WIDTH +: DATA_WIDTH];
               pushIdx_d = pushIdx_q + IW'(1);
               if (pushIdx_q == IW'(DIM - 1)) state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            mac_en = 1'b1;
            if (fifo_full_all) seenFull_d = 1'b1;
            if (seenFull_q && fifo_empty_all) begin
               tailCnt_d = '0;
               state_d   = DRAIN;
            end
         end
         DRAIN: begin
            mac_en = 1'b1;
            if (tailCnt_q == TW'(TAIL_CYC - 1)) state_d = DONE;
            else tailCnt_d = tailCnt_q + TW'(1);
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mvm_load_sequencer.sv
// Self-checking bench for mvm_load_sequencer: memory responder, FIFO/MAC model, and scoreboard queues.
module tb_mvm_load_sequencer;

   localparam int DW   = 8;
   localparam int DIM  = 8;
   localparam int AW   = 32;
   localparam int TAIL = 9;
   localparam int WW   = DIM * DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          busy, done;
   logic [15:0]   job_cycles;
   logic [AW-1:0] mem_address;
   logic          mem_read;
   logic          mem_waitrequest;
   logic [WW-1:0] mem_readdata;
   logic          mem_readdatavalid;
   logic          a_wren, b_wren;
   logic [WW-1:0] a_data;
   logic [DW-1:0] b_data;
   logic          fifo_full_all, fifo_empty_all;
   logic          mac_clr, mac_en;

   mvm_load_sequencer #(.DATA_WIDTH(DW), .DIM(DIM), .ADDR_WIDTH(AW), .TAIL_CYC(TAIL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .busy(busy), .done(done), .job_cycles(job_cycles),
      .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
      .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
      .a_wren(a_wren), .a_data(a_data), .b_wren(b_wren), .b_data(b_data),
      .fifo_full_all(fifo_full_all), .fifo_empty_all(fifo_empty_all),
      .mac_clr(mac_clr), .mac_en(mac_en)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   int nCompared = 0;
   int nMismatched = 0;

   logic [DW-1:0] matA [DIM][DIM];
   logic [DW-1:0] vecB [DIM];
   logic [WW-1:0] colWord [DIM];
   logic [WW-1:0] bWord;
   logic [AW-1:0] curBase = '0;
   logic [AW-1:0] stallAddr = '0;
   int            stallLeft = 0;

   logic [AW-1:0] expAddrQ [$];
   logic [WW-1:0] expAQ [$];
   logic [DW-1:0] expBQ [$];
   logic [WW-1:0] aFifoQ [$];
   logic [DW-1:0] bFifoQ [$];
   int            acc [DIM];

   int busyCnt, aWrenCnt, bWrenCnt, clrCnt, doneCnt, stallCycles, tailCnt;
   bit clrSeen, fullSeen, tailArmed, prevWait;
   logic [AW-1:0] prevAddr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WW-1:0] memWord(input logic [AW-1:0] addr);
      logic [AW-1:0] k;
      k = addr - curBase;
      if (k < AW'(DIM)) return colWord[k[2:0]];
      if (k == AW'(DIM)) return bWord;
      return '0;
   endfunction

   assign mem_waitrequest = mem_read && (mem_address == stallAddr) && (stallLeft != 0);

   // Memory responder and FIFO/MAC datapath model; flags are registered like real FIFO status.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aFifoQ.delete();
         bFifoQ.delete();
         fifo_full_all     <= 1'b0;
         fifo_empty_all    <= 1'b1;
         mem_readdatavalid <= 1'b0;
         mem_readdata      <= '0;
      end else begin
         logic [WW-1:0] aw;
         logic [DW-1:0] bb;
         mem_readdatavalid <= 1'b0;
         if (mem_read && !mem_waitrequest) begin
            mem_readdatavalid <= 1'b1;
            mem_readdata      <= memWord(mem_address);
         end
         if (mem_waitrequest) stallLeft <= stallLeft - 1;
         if (mac_clr) for (int i = 0; i < DIM; i++) acc[i] = 0;
         if (a_wren) aFifoQ.push_back(a_data);
         if (b_wren) bFifoQ.push_back(b_data);
         if (mac_en && aFifoQ.size() > 0 && bFifoQ.size() > 0) begin
            aw = aFifoQ.pop_front();
            bb = bFifoQ.pop_front();
            for (int i = 0; i < DIM; i++) acc[i] += int'(aw[i*DW +: DW]) * int'(bb);
         end
         fifo_full_all  <= (aFifoQ.size() == DIM) && (bFifoQ.size() == DIM);
         fifo_empty_all <= (aFifoQ.size() == 0) && (bFifoQ.size() == 0);
      end
   end

   // Output monitor on the falling edge: pops the scoreboard and checks handshake rules.
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy) busyCnt++;
         if (mem_waitrequest) stallCycles++;
         if (prevWait) begin
            check("stall_read_held", mem_read, 1);
            check("stall_addr_held", mem_address, prevAddr);
         end
         prevWait = mem_read && mem_waitrequest;
         prevAddr = mem_address;
         if (mem_read && !mem_waitrequest) begin
            check("rd_expected", expAddrQ.size() != 0, 1);
            if (expAddrQ.size() != 0) check("rd_addr", mem_address, expAddrQ.pop_front());
         end
         if (mac_clr) begin
            clrCnt++;
            clrSeen = 1'b1;
         end
         if (a_wren) begin
            aWrenCnt++;
            check("clr_before_awren", clrSeen, 1);
            check("awren_not_full", fifo_full_all, 0);
            check("a_expected", expAQ.size() != 0, 1);
            if (expAQ.size() != 0) check("a_data", a_data, expAQ.pop_front());
         end
         if (b_wren) begin
            bWrenCnt++;
            check("bwren_not_full", fifo_full_all, 0);
            check("b_expected", expBQ.size() != 0, 1);
            if (expBQ.size() != 0) check("b_data", b_data, expBQ.pop_front());
         end
         if (fifo_full_all) fullSeen = 1'b1;
         if (mac_en) begin
            if (tailArmed) tailCnt++;
            else if (fullSeen && fifo_empty_all) tailArmed = 1'b1;
         end
         if (done) begin
            doneCnt++;
            clrSeen = 1'b0;
         end
      end else begin
         prevWait = 1'b0;
         clrSeen  = 1'b0;
      end
   end

   task automatic setMatrix(input bit identity);
      for (int i = 0; i < DIM; i++) begin
         vecB[i] = identity ? DW'(i + 1) : DW'($urandom_range(0, 255));
         for (int k = 0; k < DIM; k++)
            matA[i][k] = identity ? ((i == k) ? 8'd1 : 8'd0) : DW'($urandom_range(0, 255));
      end
   endtask

   task automatic prepJob(input logic [AW-1:0] base, input int stallCol);
      curBase = base;
      for (int k = 0; k < DIM; k++) begin
         for (int i = 0; i < DIM; i++) colWord[k][i*DW +: DW] = matA[i][k];
         bWord[k*DW +: DW] = vecB[k];
      end
      busyCnt = 0; aWrenCnt = 0; bWrenCnt = 0; clrCnt = 0; doneCnt = 0;
      stallCycles = 0; tailCnt = 0; fullSeen = 1'b0; tailArmed = 1'b0;
      if (stallCol >= 0) begin
         stallAddr = base + AW'(stallCol);
         stallLeft = 5;
      end else begin
         stallLeft = 0;
      end
      for (int k = 0; k <= DIM; k++) expAddrQ.push_back(base + AW'(k));
      for (int k = 0; k < DIM; k++) expAQ.push_back(colWord[k]);
      for (int j = 0; j < DIM; j++) expBQ.push_back(vecB[j]);
   endtask

   task automatic checkZero(input string tag);
      check({tag, "_ctl"}, {busy, done, mem_read, a_wren, b_wren, mac_clr, mac_en}, 0);
      check({tag, "_addr"}, mem_address, 0);
      check({tag, "_adata"}, a_data, 0);
      check({tag, "_bdata"}, b_data, 0);
      check({tag, "_cycles"}, job_cycles, 0);
   endtask

   task automatic applyStimulus(input logic [AW-1:0] base, input int stallCol, input bit holdStart,
                                input bit startNow, input int expCycles);
      int got;
      int expAcc [DIM];
      prepJob(base, stallCol);
      for (int i = 0; i < DIM; i++) begin
         expAcc[i] = 0;
         for (int k = 0; k < DIM; k++) expAcc[i] += int'(matA[i][k]) * int'(vecB[k]);
      end
      if (!startNow) begin
         @(posedge clk); #1;
      end
      start = 1'b1;
      base_addr = base;
      @(posedge clk); #1;
      if (!holdStart) start = 1'b0;
      got = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            break;
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput(got, expCycles, stallCol, expAcc);
   endtask

   task automatic checkOutput(input int got, input int expCycles, input int stallCol, input int expAcc [DIM]);
      check("done_seen", got, 1);
      check("a_wren_count", aWrenCnt, DIM);
      check("b_wren_count", bWrenCnt, DIM);
      check("mac_clr_count", clrCnt, 1);
      check("done_count", doneCnt, 1);
      check("busy_after_done", busy, 0);
      check("job_cycles_vs_busy", job_cycles, busyCnt);
      if (expCycles >= 0) check("job_cycles_abs", job_cycles, expCycles);
      check("tail_cycles", tailCnt, TAIL);
      for (int i = 0; i < DIM; i++) check($sformatf("mac_out_%0d", i), acc[i], expAcc[i]);
      check("addr_q_drained", expAddrQ.size(), 0);
      check("a_q_drained", expAQ.size(), 0);
      check("b_q_drained", expBQ.size(), 0);
      if (stallCol >= 0) check("stall_cycles", stallCycles, 5);
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence of jobs.
   initial begin
      int got;
      repeat (3) @(posedge clk);
      #1 checkZero("reset");
      @(negedge clk) rst_n = 1'b1;

      $display("[TB] job 1: zero-latency memory, identity matrix");
      setMatrix(1'b1);
      applyStimulus(32'h0000_0100, -1, 1'b0, 1'b0, 54);

      $display("[TB] job 2: waitrequest stall on column 3");
      applyStimulus(32'h0000_0100, 3, 1'b0, 1'b0, 59);

      $display("[TB] job 3: start held high through the job");
      applyStimulus(32'h0000_0100, -1, 1'b1, 1'b0, 54);
      repeat (3) @(negedge clk);
      check("hold_no_restart_busy", busy, 0);
      check("hold_one_clr", clrCnt, 1);
      check("hold_one_done", doneCnt, 1);

      $display("[TB] job 4: reset during column 4 read");
      prepJob(32'h0000_0200, -1);
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = 32'h0000_0200;
      @(posedge clk); #1;
      start = 1'b0;
      got = 0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (mem_read && mem_address == 32'h0000_0204) begin
            got = 1;
            break;
         end
      end
      check("col4_reached", got, 1);
      #2 rst_n = 1'b0;
      #1 checkZero("async_reset");
      check("abort_a_wren_count", aWrenCnt, 4);
      check("abort_no_done", doneCnt, 0);
      expAddrQ.delete();
      expAQ.delete();
      expBQ.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      applyStimulus(32'h0000_0200, -1, 1'b0, 1'b0, 54);

      $display("[TB] job 5: address wrap at top of memory");
      setMatrix(1'b0);
      applyStimulus(32'hFFFF_FFFC, -1, 1'b0, 1'b0, 54);

      $display("[TB] job 6: back-to-back start");
      setMatrix(1'b0);
      applyStimulus(32'h0000_0040, -1, 1'b0, 1'b1, 54);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
